skeleton_pass_controller: RTL and testbench
===========================================

# skeleton_pass_controller

Iteration controller on the far side of the convolutional mask unit. Holds an N×N 8-bit frame buffer, streams it pixel by pixel into the mask's load port, then captures the mask's write-out stream back into the buffer. Repeats passes until a pass changes no pixel or an iteration cap is reached. Sits between the host image loader and the mask unit, and is the only writer of the working image during skeletonization.

## Interface
- N, default 8: image edge length; the frame holds N*N pixels.
- bitSize, default 6: address MSB index; addresses are bitSize+1 bits wide.
- HOLD, default 2: cycles each load pixel is held, matching the mask's half-rate sampling.
- MAX_ITER, default 16: maximum number of passes.
- WAIT_LIMIT, default 255: maximum cycles to wait for write-out to begin.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE.
- host_we  in  1  host frame write strobe.
- host_addr  in  bitSize+1  host frame address, for both read and write.
- host_wdata  in  8  host write data.
- host_rdata  out  8  frame read data, registered.
- mask_we  out  1  load strobe to the mask.
- mask_data  out  8  load pixel to the mask.
- mask_ret_en  in  1  mask write-out enable.
- mask_ret_addr  in  bitSize+1  mask write-out address.
- mask_ret_data  in  8  mask write-out pixel.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- timeout  out  1  sticky error flag; cleared by start.
- iter_count  out  8  number of passes completed in the current or last run.

## Operation
- States: IDLE, LOAD, WAIT, CAPTURE, CHECK, FINISH.
- IDLE
  - host_we writes fb[host_addr] <= host_wdata.
  - start moves to LOAD and clears iter_count, timeout, pix_idx, hold_cnt and chg_cnt.
- LOAD
  - mask_we = 1 and mask_data = fb[pix_idx].
  - hold_cnt counts 0..HOLD-1. On wrap, pix_idx increments.
  - After pixel N*N-1 completes its hold: mask_we drops and the state moves to WAIT. LOAD lasts exactly N*N*HOLD cycles.
- WAIT
  - mask_ret_en = 1 moves to CAPTURE; that same cycle is treated as a capture cycle.
  - If WAIT_LIMIT cycles pass without mask_ret_en: set timeout and go to FINISH.
- CAPTURE
  - On a cycle with mask_ret_en = 1 and mask_ret_addr != last_addr, or the first capture of the pass:
    - write fb[mask_ret_addr] <= mask_ret_data and update last_addr;
    - if mask_ret_data != old fb value, increment chg_cnt, saturating at N*N.
  - A repeated address is a no-op, because the mask holds each output for two cycles.
  - Addresses >= N*N are ignored.
  - mask_ret_en falling to 0 moves to CHECK.
- CHECK
  - iter_count increments, saturating at 255.
  - If chg_cnt == 0 or iter_count (new value) == MAX_ITER: go to FINISH.
  - Otherwise clear chg_cnt, pix_idx and hold_cnt, and go to LOAD.
- FINISH: done = 1 for one cycle, then IDLE.
- host_we while busy is ignored. start while busy is ignored.
- The host read port is always live: host_rdata <= fb[host_addr] every cycle. During a run it returns in-flight data.

## Timing
- Reset values: host_rdata 0, mask_we 0, mask_data 0, busy 0, done 0, timeout 0, iter_count 0; state IDLE.
- The frame buffer is not reset.
- Reset asserted mid-run: returns to IDLE immediately and asynchronously. Frame contents are undefined for that run.
- start sampled in IDLE at cycle t: busy and mask_we are high at t+1.
- mask_data changes only on hold boundaries.
- Capture write is visible on host_rdata 2 cycles after the capture cycle: one cycle for the write, one for the registered read.
- CHECK takes 1 cycle. FINISH takes 1 cycle. done is followed by busy = 0 in the next cycle.
- A pass with L capture cycles takes N*N*HOLD + wait + L + 1 cycles.
- Simultaneous mask_ret_en and WAIT-limit expiry in the same cycle: capture wins and no timeout is raised.

## Test plan
- Load all-zero frame, start, mask returns 64 zeros at HOLD=2 → one pass, iter_count = 1, done pulse, timeout = 0, frame unchanged.
- Load a 4×4 block of 0xFF at rows/cols 2..5; the mask model clears one pixel per pass for 3 passes, then returns an identical frame → iter_count = 4, and host reads show exactly 3 pixels cleared.
- Mask model always changes pixel 9 → run stops with iter_count = 16 (MAX_ITER) and done asserted.
- Mask model never raises mask_ret_en → timeout = 1 exactly 255 cycles after LOAD ends; done pulses; iter_count = 0.
- Each return address held for 2 cycles with differing data on the second cycle → only the first value is written, and chg_cnt counts once.
- Assert rst_n low in the middle of LOAD → mask_we = 0, busy = 0 and state IDLE immediately; a following start runs normally; host_we issued during a run → no frame change.

Source files
------------

// File: rtl/skeleton_pass_controller.sv
// skeleton_pass_controller: iteration controller for the convolutional mask unit.
// Owns an N x N 8-bit frame buffer. Each pass streams the frame into the mask's
// load port (each pixel held HOLD cycles), then captures the mask's write-out
// stream back into the buffer. Passes repeat until one changes no pixel or
// MAX_ITER passes have run.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start                              begins a run from IDLE
//   host_we/host_addr/host_wdata       host frame write (IDLE only)
//   host_rdata                         registered frame read of host_addr
//   mask_we/mask_data                  load stream to the mask
//   mask_ret_en/_addr/_data            write-out stream from the mask
//   busy, done, timeout, iter_count    run status
module skeleton_pass_controller #(
  parameter int unsigned N          = 8,
  parameter int unsigned bitSize    = 6,
  parameter int unsigned HOLD       = 2,
  parameter int unsigned MAX_ITER   = 16,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             host_we,
  input  logic [bitSize:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             mask_we,
  output logic [7:0]       mask_data,
  input  logic             mask_ret_en,
  input  logic [bitSize:0] mask_ret_addr,
  input  logic [7:0]       mask_ret_data,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [7:0]       iter_count
);

  localparam int unsigned NPIX = N * N;
  localparam int unsigned AW   = bitSize + 1;
  localparam int unsigned PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned HW   = $clog2(HOLD + 1);
  localparam int unsigned WW   = $clog2(WAIT_LIMIT + 1);
  localparam int unsigned CW   = $clog2(NPIX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_CAPTURE, S_CHECK, S_FINISH
  } state_t;

  logic [7:0]    fb [NPIX];
  state_t        state, state_d;
  logic [PW-1:0] pix_idx, pix_idx_d, pix_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_d;
  logic [WW-1:0] wait_cnt, wait_cnt_d;
  logic [CW-1:0] chg_cnt, chg_cnt_d;
  logic [AW-1:0] last_addr, last_addr_d;
  logic          first_cap, first_cap_d;
  logic          mask_we_d, busy_d, done_d, timeout_d;
  logic [7:0]    mask_data_d, iter_count_d, iter_inc;
  logic [PW-1:0] host_idx, ret_idx;
  logic          host_in_range, ret_in_range, cap_fire;

  // Addresses beyond the frame are dropped rather than aliased.
  assign host_idx      = PW'(host_addr);
  assign ret_idx       = PW'(mask_ret_addr);
  assign host_in_range = (32'(host_addr) < NPIX);
  assign ret_in_range  = (32'(mask_ret_addr) < NPIX);
  assign pix_nxt       = pix_idx + PW'(1);
  assign iter_inc      = (iter_count == 8'hFF) ? 8'hFF : iter_count + 8'd1;

  // The mask holds each output for two cycles, so only a new address is a capture.
  assign cap_fire = mask_ret_en && ret_in_range &&
                    (first_cap || (mask_ret_addr != last_addr)) &&
                    ((state == S_WAIT) || (state == S_CAPTURE));

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    pix_idx_d    = pix_idx;
    hold_cnt_d   = hold_cnt;
    wait_cnt_d   = wait_cnt;
    chg_cnt_d    = chg_cnt;
    last_addr_d  = last_addr;
    first_cap_d  = first_cap;
    mask_we_d    = 1'b0;
    mask_data_d  = mask_data;
    done_d       = 1'b0;
    timeout_d    = timeout;
    iter_count_d = iter_count;

    if (cap_fire) begin
      last_addr_d = mask_ret_addr;
      first_cap_d = 1'b0;
      if ((mask_ret_data != fb[ret_idx]) && (chg_cnt != CW'(NPIX)))
        chg_cnt_d = chg_cnt + CW'(1);
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOAD;
          iter_count_d = '0;
          timeout_d    = 1'b0;
          pix_idx_d    = '0;
          hold_cnt_d   = '0;
          chg_cnt_d    = '0;
          mask_we_d    = 1'b1;
          mask_data_d  = fb[PW'(0)];
        end
      end
      S_LOAD: begin
        mask_we_d = 1'b1;
        if (hold_cnt == HW'(HOLD - 1)) begin
          hold_cnt_d = '0;
          if (pix_idx == PW'(NPIX - 1)) begin
            mask_we_d   = 1'b0;
            state_d     = S_WAIT;
            wait_cnt_d  = '0;
            first_cap_d = 1'b1;
          end else begin
            pix_idx_d   = pix_nxt;
            mask_data_d = fb[pix_nxt];
          end
        end else begin
          hold_cnt_d = hold_cnt + HW'(1);
        end
      end
      S_WAIT: begin
        // A write-out arriving on the expiry cycle still wins.
        if (mask_ret_en) begin
          state_d = S_CAPTURE;
        end else if (wait_cnt == WW'(WAIT_LIMIT - 1)) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_FINISH;
        end else begin
          wait_cnt_d = wait_cnt + WW'(1);
        end
      end
      S_CAPTURE: begin
        if (!mask_ret_en) state_d = S_CHECK;
      end
      S_CHECK: begin
        iter_count_d = iter_inc;
        if ((chg_cnt == '0) || (32'(iter_inc) == MAX_ITER)) begin
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          chg_cnt_d   = '0;
          pix_idx_d   = '0;
          hold_cnt_d  = '0;
          mask_we_d   = 1'b1;
          mask_data_d = fb[PW'(0)];
          state_d     = S_LOAD;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pix_idx    <= '0;
      hold_cnt   <= '0;
      wait_cnt   <= '0;
      chg_cnt    <= '0;
      last_addr  <= '0;
      first_cap  <= 1'b0;
      mask_we    <= 1'b0;
      mask_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      iter_count <= '0;
      host_rdata <= '0;
    end else begin
      state      <= state_d;
      pix_idx    <= pix_idx_d;
      hold_cnt   <= hold_cnt_d;
      wait_cnt   <= wait_cnt_d;
      chg_cnt    <= chg_cnt_d;
      last_addr  <= last_addr_d;
      first_cap  <= first_cap_d;
      mask_we    <= mask_we_d;
      mask_data  <= mask_data_d;
      busy       <= busy_d;
      done       <= done_d;
      timeout    <= timeout_d;
      iter_count <= iter_count_d;
      host_rdata <= host_in_range ? fb[host_idx] : 8'h00;
    end
  end

  // Frame buffer: host writes only while idle, mask captures only during a run.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && host_we && host_in_range)
      fb[host_idx] <= host_wdata;
    else if (cap_fire)
      fb[ret_idx] <= mask_ret_data;
  end

endmodule

// File: tb/tb_skeleton_pass_controller.sv
// Bench for skeleton_pass_controller: the bench plays host and mask unit.
module tb_skeleton_pass_controller;

  localparam int unsigned N          = 8;
  localparam int unsigned NPIX       = N * N;
  localparam int unsigned HOLD       = 2;
  localparam int unsigned MAX_ITER   = 16;
  localparam int unsigned WAIT_LIMIT = 255;
  localparam int unsigned LOAD_CYC   = NPIX * HOLD;

  localparam int M_IDENT  = 0;
  localparam int M_CLEAR3 = 1;
  localparam int M_PIX9   = 2;
  localparam int M_NEVER  = 3;

  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       chk_en;
    logic [7:0] exp_d;
  } hv_t;

  logic       clk = 1'b0;
  logic       rst_n, start, host_we;
  logic [6:0] host_addr, mask_ret_addr;
  logic [7:0] host_wdata, host_rdata, mask_data, mask_ret_data, iter_count;
  logic       mask_we, mask_ret_en, busy, done, timeout;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] model_fb [NPIX];
  logic [7:0] exp_q [$];
  hv_t        vec [9];

  skeleton_pass_controller #(
    .N(8), .bitSize(6), .HOLD(2), .MAX_ITER(16), .WAIT_LIMIT(255)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .mask_we(mask_we), .mask_data(mask_data),
    .mask_ret_en(mask_ret_en), .mask_ret_addr(mask_ret_addr), .mask_ret_data(mask_ret_data),
    .busy(busy), .done(done), .timeout(timeout), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp_v);
    end
  endfunction

  task automatic host_write(input int a, input logic [7:0] d);
    host_we = 1'b1; host_addr = 7'(a); host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic load_frame();
    for (int a = 0; a < int'(NPIX); a++) host_write(a, model_fb[a]);
  endtask

  // Pipelined readback: expected value queued at address issue, popped when it returns.
  task automatic read_all(input string tag, output int ff_cnt);
    logic [7:0] e;
    ff_cnt = 0;
    exp_q.delete();
    for (int a = 0; a <= int'(NPIX); a++) begin
      if (a > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("%s_rd[%0d]", tag, a - 1), host_rdata, e);
        if (host_rdata == 8'hFF) ff_cnt++;
      end
      if (a < int'(NPIX)) begin
        host_addr = 7'(a);
        exp_q.push_back(model_fb[a]);
      end
      @(negedge clk);
    end
  endtask

  // One full run; the bench answers each load with a write-out computed from its own frame model.
  task automatic run_job(input int mode, input bit poke, input int exp_iter);
    logic [7:0] loaded [NPIX];
    logic [7:0] outf [NPIX];
    logic [7:0] e;
    int  pass, cyc, k, chg;
    bit  stop, found;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_mask_we", mask_we, 1);
    chk("start_timeout_clr", timeout, 0);
    chk("start_iter_clr", iter_count, 0);
    pass = 0;
    stop = 1'b0;
    while (!stop) begin
      exp_q.delete();
      for (int p = 0; p < int'(NPIX); p++) exp_q.push_back(model_fb[p]);
      cyc = 0;
      while (mask_we === 1'b1 && cyc < int'(LOAD_CYC) + 8) begin
        if (cyc < int'(LOAD_CYC)) begin
          if (cyc % HOLD == 0) begin
            e = exp_q.pop_front();
            loaded[cyc / HOLD] = mask_data;
            chk($sformatf("load_pix[%0d]", cyc / HOLD), mask_data, e);
          end else begin
            chk("load_hold", mask_data, loaded[cyc / HOLD]);
          end
        end
        host_we    = poke && (pass == 0) && (cyc == 5);
        host_addr  = 7'd10;
        host_wdata = 8'h77;
        @(negedge clk);
        cyc++;
      end
      host_we = 1'b0;
      chk("load_len", cyc, LOAD_CYC);

      if (mode == M_NEVER) begin
        k = 0;
        while (timeout !== 1'b1 && k < int'(WAIT_LIMIT) + 20) begin
          @(negedge clk);
          k++;
        end
        chk("timeout_delay", k, WAIT_LIMIT);
        chk("timeout_done", done, 1);
        chk("timeout_iter", iter_count, 0);
        chk("timeout_busy_finish", busy, 1);
        @(negedge clk);
        chk("timeout_busy_after", busy, 0);
        chk("timeout_done_after", done, 0);
        chk("timeout_sticky", timeout, 1);
        stop = 1'b1;
      end else begin
        for (int p = 0; p < int'(NPIX); p++) outf[p] = model_fb[p];
        if (mode == M_CLEAR3 && pass < 3) begin
          found = 1'b0;
          for (int p = 0; p < int'(NPIX); p++)
            if (!found && outf[p] == 8'hFF) begin
              outf[p] = 8'h00;
              found = 1'b1;
            end
        end
        if (mode == M_PIX9) outf[9] = model_fb[9] + 8'd1;
        chg = 0;
        for (int p = 0; p < int'(NPIX); p++) begin
          if (outf[p] != model_fb[p]) chg++;
          model_fb[p] = outf[p];
        end
        repeat (3) @(negedge clk);
        // Second cycle of each held address carries different data that must be ignored.
        for (int p = 0; p < int'(NPIX); p++) begin
          mask_ret_en = 1'b1; mask_ret_addr = 7'(p); mask_ret_data = outf[p];
          @(negedge clk);
          mask_ret_data = outf[p] ^ 8'hA5;
          @(negedge clk);
        end
        mask_ret_addr = 7'(NPIX + 9); mask_ret_data = 8'h99;
        repeat (2) @(negedge clk);
        mask_ret_en = 1'b0; mask_ret_addr = '0; mask_ret_data = '0;
        pass++;
        stop = (chg == 0) || (pass == int'(MAX_ITER));
        k = 0;
        if (stop) begin
          while (done !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
          end
          chk("done_pulse", done, 1);
          chk("final_iter", iter_count, exp_iter);
          chk("final_iter_vs_passes", iter_count, pass);
          chk("final_timeout", timeout, 0);
          @(negedge clk);
          chk("after_done_busy", busy, 0);
          chk("after_done_done", done, 0);
        end else begin
          while (mask_we !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
          end
          chk("next_pass_load", mask_we, 1);
          chk("pass_iter", iter_count, pass);
        end
      end
    end
  endtask

  initial begin
    int ffc;
    vec[0] = '{1'b1, 7'd3,  8'h11, 1'b0, 8'h00};
    vec[1] = '{1'b1, 7'd6,  8'h66, 1'b0, 8'h00};
    vec[2] = '{1'b0, 7'd3,  8'h00, 1'b1, 8'h11};
    vec[3] = '{1'b1, 7'd3,  8'h22, 1'b1, 8'h11};
    vec[4] = '{1'b0, 7'd3,  8'h00, 1'b1, 8'h22};
    vec[5] = '{1'b1, 7'd73, 8'hEE, 1'b0, 8'h00};
    vec[6] = '{1'b0, 7'd6,  8'h00, 1'b1, 8'h66};
    vec[7] = '{1'b1, 7'd63, 8'h3F, 1'b0, 8'h00};
    vec[8] = '{1'b0, 7'd63, 8'h00, 1'b1, 8'h3F};

    rst_n = 1'b0; start = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    mask_ret_en = 1'b0; mask_ret_addr = '0; mask_ret_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_mask_we", mask_we, 0);
    chk("rst_mask_data", mask_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_iter", iter_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Host port vectors while idle.
    for (int i = 0; i < 9; i++) begin
      host_we = vec[i].we; host_addr = vec[i].addr; host_wdata = vec[i].wdata;
      @(negedge clk);
      if (vec[i].chk_en) chk($sformatf("host_vec[%0d]", i), host_rdata, vec[i].exp_d);
    end
    host_we = 1'b0;

    // All-zero frame, mask returns it unchanged.
    for (int p = 0; p < int'(NPIX); p++) model_fb[p] = 8'h00;
    load_frame();
    run_job(M_IDENT, 1'b0, 1);
    read_all("zero", ffc);

    // 4x4 block of 0xFF, three pixels cleared over three passes.
    for (int p = 0; p < int'(NPIX); p++)
      model_fb[p] = ((p / N) >= 2 && (p / N) <= 5 && (p % N) >= 2 && (p % N) <= 5) ? 8'hFF : 8'h00;
    load_frame();
    run_job(M_CLEAR3, 1'b0, 4);
    read_all("block", ffc);
    chk("block_ff_count", ffc, 13);

    // Pixel 9 changes every pass: iteration cap ends the run.
    for (int p = 0; p < int'(NPIX); p++) model_fb[p] = 8'h00;
    load_frame();
    run_job(M_PIX9, 1'b0, 16);
    read_all("cap", ffc);

    // Mask never answers.
    run_job(M_NEVER, 1'b0, 0);

    // A fresh start clears the sticky timeout.
    run_job(M_IDENT, 1'b0, 1);

    // Reset in the middle of LOAD.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mask_we", mask_we, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_iter", iter_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal run after reset, with a host write attempted mid-run.
    for (int p = 0; p < int'(NPIX); p++) model_fb[p] = 8'($urandom_range(0, 255));
    model_fb[10] = 8'h10;
    load_frame();
    run_job(M_IDENT, 1'b1, 1);
    read_all("poke", ffc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
